// File: rtl/logic_axi4_stream_packet_splitter.sv
// AXI4-Stream packet splitter: caps output packets at MAX_TRANSFERS beats by
// forcing tlast, behind a fully registered 2-entry skid buffer (output
// register + skid register). rx_tready comes straight from the skid flop.
// Optional build macro LOGIC_AXI4_STREAM_PACKET_SPLITTER_STATS_EN adds a
// saturating 32-bit split_total counter port.
module logic_axi4_stream_packet_splitter #(
    parameter int TDATA_BYTES   = 1,
    parameter int TDEST_WIDTH   = 1,
    parameter int TUSER_WIDTH   = 1,
    parameter int TID_WIDTH     = 1,
    parameter int MAX_TRANSFERS = 256
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       rx_tvalid,
    output logic                       rx_tready,
    input  logic                       rx_tlast,
    input  logic [TDATA_BYTES*8-1:0]   rx_tdata,
    input  logic [TDATA_BYTES-1:0]     rx_tstrb,
    input  logic [TDATA_BYTES-1:0]     rx_tkeep,
    input  logic [TDEST_WIDTH-1:0]     rx_tdest,
    input  logic [TUSER_WIDTH-1:0]     rx_tuser,
    input  logic [TID_WIDTH-1:0]       rx_tid,
    output logic                       tx_tvalid,
    input  logic                       tx_tready,
    output logic                       tx_tlast,
    output logic [TDATA_BYTES*8-1:0]   tx_tdata,
    output logic [TDATA_BYTES-1:0]     tx_tstrb,
    output logic [TDATA_BYTES-1:0]     tx_tkeep,
    output logic [TDEST_WIDTH-1:0]     tx_tdest,
    output logic [TUSER_WIDTH-1:0]     tx_tuser,
    output logic [TID_WIDTH-1:0]       tx_tid,
    output logic                       split
`ifdef LOGIC_AXI4_STREAM_PACKET_SPLITTER_STATS_EN
    ,
    output logic [31:0]                split_total
`endif
);

    localparam int CW = (MAX_TRANSFERS > 1) ? $clog2(MAX_TRANSFERS) : 1;

    typedef struct packed {
        logic                     tlast;
        logic [TDATA_BYTES*8-1:0] tdata;
        logic [TDATA_BYTES-1:0]   tstrb;
        logic [TDATA_BYTES-1:0]   tkeep;
        logic [TDEST_WIDTH-1:0]   tdest;
        logic [TUSER_WIDTH-1:0]   tuser;
        logic [TID_WIDTH-1:0]     tid;
    } beat_t;

    beat_t          rx_beat;
    beat_t          out_q;
    beat_t          skid_q;
    logic           out_valid;
    logic           skid_valid;
    logic [CW-1:0]  beat_count;
    logic           last_out;
    logic           rx_acc;
    logic           out_free;

    assign rx_tready = ~skid_valid;
    assign rx_acc    = rx_tvalid & rx_tready;
    // Output register can take a new beat when empty or being emitted now.
    assign out_free  = ~out_valid | tx_tready;
    assign last_out  = rx_tlast | (beat_count == CW'(MAX_TRANSFERS - 1));

    assign rx_beat.tlast = last_out;
    assign rx_beat.tdata = rx_tdata;
    assign rx_beat.tstrb = rx_tstrb;
    assign rx_beat.tkeep = rx_tkeep;
    assign rx_beat.tdest = rx_tdest;
    assign rx_beat.tuser = rx_tuser;
    assign rx_beat.tid   = rx_tid;

    assign tx_tvalid = out_valid;
    assign tx_tlast  = out_q.tlast;
    assign tx_tdata  = out_q.tdata;
    assign tx_tstrb  = out_q.tstrb;
    assign tx_tkeep  = out_q.tkeep;
    assign tx_tdest  = out_q.tdest;
    assign tx_tuser  = out_q.tuser;
    assign tx_tid    = out_q.tid;

    // Skid buffer: the skid drains first so beat order is preserved; rx can
    // only be accepted while the skid is empty.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (rx_acc) begin
                out_q     <= rx_beat;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (rx_acc) begin
            skid_q     <= rx_beat;
            skid_valid <= 1'b1;
        end
    end

    // Per-beat position counter; wraps on every real or forced tlast.
    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_count <= '0;
        end else if (rx_acc) begin
            beat_count <= last_out ? '0 : beat_count + CW'(1);
        end
    end

    // One-cycle pulse after accepting a beat whose tlast was forced.
    always_ff @(posedge aclk) begin
        if (areset) begin
            split <= 1'b0;
        end else begin
            split <= rx_acc & last_out & ~rx_tlast;
        end
    end

`ifdef LOGIC_AXI4_STREAM_PACKET_SPLITTER_STATS_EN
    // Saturating count of split pulses.
    always_ff @(posedge aclk) begin
        if (areset) begin
            split_total <= '0;
        end else if (split && (split_total != 32'hFFFF_FFFF)) begin
            split_total <= split_total + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_axi4_stream_packet_splitter.sv
// Bench for logic_axi4_stream_packet_splitter: four instances with
// MAX_TRANSFERS = 4, 256, 1, 2 driven by directed packet tables.
module tb_logic_axi4_stream_packet_splitter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       areset    [N];
    logic       rx_tvalid [N];
    logic       rx_tready [N];
    logic       rx_tlast  [N];
    logic [7:0] rx_tdata  [N];
    logic [0:0] rx_tstrb  [N];
    logic [0:0] rx_tkeep  [N];
    logic [0:0] rx_tdest  [N];
    logic [0:0] rx_tuser  [N];
    logic [0:0] rx_tid    [N];
    logic       tx_tvalid [N];
    logic       tx_tready [N];
    logic       tx_tlast  [N];
    logic [7:0] tx_tdata  [N];
    logic [0:0] tx_tstrb  [N];
    logic [0:0] tx_tkeep  [N];
    logic [0:0] tx_tdest  [N];
    logic [0:0] tx_tuser  [N];
    logic [0:0] tx_tid    [N];
    logic       split     [N];
`ifdef LOGIC_AXI4_STREAM_PACKET_SPLITTER_STATS_EN
    logic [31:0] split_total [N];
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic_axi4_stream_packet_splitter #(
            .TDATA_BYTES   (1),
            .TDEST_WIDTH   (1),
            .TUSER_WIDTH   (1),
            .TID_WIDTH     (1),
            .MAX_TRANSFERS (g == 0 ? 4 : g == 1 ? 256 : g == 2 ? 1 : 2)
        ) dut (
            .aclk      (clk),
            .areset    (areset[g]),
            .rx_tvalid (rx_tvalid[g]),
            .rx_tready (rx_tready[g]),
            .rx_tlast  (rx_tlast[g]),
            .rx_tdata  (rx_tdata[g]),
            .rx_tstrb  (rx_tstrb[g]),
            .rx_tkeep  (rx_tkeep[g]),
            .rx_tdest  (rx_tdest[g]),
            .rx_tuser  (rx_tuser[g]),
            .rx_tid    (rx_tid[g]),
            .tx_tvalid (tx_tvalid[g]),
            .tx_tready (tx_tready[g]),
            .tx_tlast  (tx_tlast[g]),
            .tx_tdata  (tx_tdata[g]),
            .tx_tstrb  (tx_tstrb[g]),
            .tx_tkeep  (tx_tkeep[g]),
            .tx_tdest  (tx_tdest[g]),
            .tx_tuser  (tx_tuser[g]),
            .tx_tid    (tx_tid[g]),
            .split     (split[g])
`ifdef LOGIC_AXI4_STREAM_PACKET_SPLITTER_STATS_EN
            ,
            .split_total (split_total[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one or two back-to-back packets (len2 may be 0) with rx_tvalid
    // held high; mode 0: tx_tready=1, mode 1: tx_tready pattern 1,0,0,1.
    task automatic stream(input int idx, input int max, input int len1, input int len2,
                          input int mode, input int base, input bit chk_lat,
                          input int exp_splits, input int exp_lasts, input string nm);
        int total, sent, got, cyc, occ, mcnt, first_acc, splits_seen, lasts_seen;
        bit exp_split, stall_prev, nat, acc, emit, lastx, forced;
        logic [7:0] prev_data, d;
        logic       prev_last;
        logic [8:0] expq[$];
        logic [8:0] e;
        total = len1 + len2;
        sent = 0; got = 0; cyc = 0; occ = 0; mcnt = 0; first_acc = 0;
        splits_seen = 0; lasts_seen = 0;
        exp_split = 0; stall_prev = 0; prev_data = '0; prev_last = 0;
        while (got < total && cyc < 4 * total + 20) begin
            @(negedge clk);
            nat = (sent == len1 - 1) || (sent == total - 1);
            d   = 8'(base + sent);
            rx_tvalid[idx] = (sent < total);
            rx_tdata[idx]  = d;
            rx_tlast[idx]  = nat;
            rx_tuser[idx]  = d[0];
            rx_tid[idx]    = d[1];
            rx_tdest[idx]  = d[2];
            rx_tstrb[idx]  = d[3];
            rx_tkeep[idx]  = d[4];
            tx_tready[idx] = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            #1;
            check($sformatf("%s:split@%0d", nm, cyc), 32'(split[idx]), 32'(exp_split));
            if (split[idx]) splits_seen++;
            check($sformatf("%s:rx_tready@%0d", nm, cyc), 32'(rx_tready[idx]), 32'(occ < 2));
            if (stall_prev) begin
                check($sformatf("%s:stall_data@%0d", nm, cyc), 32'(tx_tdata[idx]), 32'(prev_data));
                check($sformatf("%s:stall_last@%0d", nm, cyc), 32'(tx_tlast[idx]), 32'(prev_last));
                check($sformatf("%s:stall_valid@%0d", nm, cyc), 32'(tx_tvalid[idx]), 32'd1);
            end
            acc  = rx_tvalid[idx] && rx_tready[idx];
            emit = tx_tvalid[idx] && tx_tready[idx];
            if (emit) begin
                e = (expq.size() > 0) ? expq.pop_front() : 9'h1FF;
                check($sformatf("%s:data#%0d", nm, got), 32'(tx_tdata[idx]), 32'(e[7:0]));
                check($sformatf("%s:last#%0d", nm, got), 32'(tx_tlast[idx]), 32'(e[8]));
                check($sformatf("%s:side#%0d", nm, got),
                      32'({tx_tkeep[idx], tx_tstrb[idx], tx_tdest[idx], tx_tid[idx], tx_tuser[idx]}),
                      32'(e[4:0]));
                if (tx_tlast[idx]) lasts_seen++;
                if (chk_lat && got == 0)
                    check($sformatf("%s:latency", nm), 32'(cyc), 32'(first_acc + 1));
                got++;
            end
            exp_split = 0;
            if (acc) begin
                forced = (mcnt == max - 1) && !nat;
                lastx  = nat || (mcnt == max - 1);
                mcnt   = lastx ? 0 : mcnt + 1;
                expq.push_back({lastx, d});
                exp_split = forced;
                if (sent == 0) first_acc = cyc;
                sent++;
            end
            occ = occ + int'(acc) - int'(emit);
            stall_prev = tx_tvalid[idx] && !tx_tready[idx];
            prev_data  = tx_tdata[idx];
            prev_last  = tx_tlast[idx];
            cyc++;
        end
        check($sformatf("%s:beats_out", nm), 32'(got), 32'(total));
        check($sformatf("%s:splits", nm), 32'(splits_seen), 32'(exp_splits));
        check($sformatf("%s:lasts", nm), 32'(lasts_seen), 32'(exp_lasts));
        @(negedge clk);
        rx_tvalid[idx] = 1'b0;
        tx_tready[idx] = 1'b1;
        #1;
        check($sformatf("%s:split_tail", nm), 32'(split[idx]), 32'(exp_split));
        check($sformatf("%s:idle_valid", nm), 32'(tx_tvalid[idx]), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            areset[i]    = 1'b1;
            rx_tvalid[i] = 1'b0;
            rx_tlast[i]  = 1'b0;
            rx_tdata[i]  = '0;
            rx_tstrb[i]  = '0;
            rx_tkeep[i]  = '0;
            rx_tdest[i]  = '0;
            rx_tuser[i]  = '0;
            rx_tid[i]    = '0;
            tx_tready[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst%0d:tx_tvalid", i), 32'(tx_tvalid[i]), 32'd0);
            check($sformatf("rst%0d:split", i), 32'(split[i]), 32'd0);
            check($sformatf("rst%0d:tx_tdata", i), 32'(tx_tdata[i]), 32'd0);
            areset[i] = 1'b0;
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++)
            check($sformatf("rst%0d:rx_tready", i), 32'(rx_tready[i]), 32'd1);

        // MAX=4, 10-beat packet: tlast on 4, 8, 10; two splits.
        stream(0, 4, 10, 0, 0, 8'h01, 1'b1, 2, 3, "split10");
        // MAX=4, 4-beat then 3-beat packet: tlast on 4 and 7, no split.
        stream(0, 4, 4, 3, 0, 8'h40, 1'b1, 0, 2, "exact4");
        // MAX=256, 300 beats with tx_tready 1,0,0,1: tlast on 256 and 300.
        stream(1, 256, 300, 0, 1, 8'h00, 1'b0, 1, 2, "long300");
        // MAX=1, 3 beats: every beat last, splits for beats 1 and 2.
        stream(2, 1, 3, 0, 0, 8'h20, 1'b1, 2, 3, "max1");

        // Reset with output and skid full: buffered beats must vanish.
        @(negedge clk);
        tx_tready[0] = 1'b0;
        rx_tvalid[0] = 1'b1;
        rx_tlast[0]  = 1'b0;
        rx_tdata[0]  = 8'h10;
        @(negedge clk);
        rx_tdata[0]  = 8'h11;
        @(negedge clk);
        rx_tvalid[0] = 1'b0;
        #1;
        check("midrst:skid_full", 32'(rx_tready[0]), 32'd0);
        check("midrst:pre_valid", 32'(tx_tvalid[0]), 32'd1);
        areset[0] = 1'b1;
        @(negedge clk);
        #1;
        check("midrst:tx_tvalid", 32'(tx_tvalid[0]), 32'd0);
        check("midrst:rx_tready", 32'(rx_tready[0]), 32'd1);
        check("midrst:split", 32'(split[0]), 32'd0);
        areset[0]    = 1'b0;
        tx_tready[0] = 1'b1;
        // After reset, 5-beat packet counts from 0: tlast on 4 and 5.
        stream(0, 4, 5, 0, 0, 8'h80, 1'b1, 1, 2, "postrst");

        // MAX=2, 7-beat packet: tlast on 2,4,6,7; three splits.
        stream(3, 2, 7, 0, 0, 8'hC0, 1'b1, 3, 4, "max2");
`ifdef LOGIC_AXI4_STREAM_PACKET_SPLITTER_STATS_EN
        check("stats:total", split_total[3], 32'd3);
        @(negedge clk);
        areset[3] = 1'b1;
        @(negedge clk);
        #1;
        check("stats:reset", split_total[3], 32'd0);
        areset[3] = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
